// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer: register map offsets,
// sequencer states, result codes and the latched command bundle.
package timer_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_LOAD   = 32'h04;
    localparam logic [31:0] OFF_WDMAX  = 32'h08;
    localparam logic [31:0] OFF_PWM    = 32'h0C;
    localparam logic [31:0] OFF_COUNT  = 32'h10;
    localparam logic [31:0] OFF_STATUS = 32'h14;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PWM,
        S_WR_WDMAX,
        S_WR_CTRL,
        S_WR_LOAD,
        S_SETTLE,
        S_POLL,
        S_DISARM,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        RES_OK      = 2'b00,
        RES_TIMEOUT = 2'b01,
        RES_ABORT   = 2'b10,
        RES_BUS_ERR = 2'b11
    } result_e;

    typedef struct packed {
        logic [31:0] load;
        logic [31:0] pwm;
        logic [31:0] wdmax;
        logic [1:0]  mode;
        logic        keep;
    } cmd_t;

endpackage

// File: rtl/timer_seq_if.sv
// Command side and timer register port of the sequencer in one bundle.
// master = sequencer view, slave = requester plus timer view.
interface timer_seq_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_load;
    logic [31:0] cmd_pwm_thres;
    logic [31:0] cmd_wd_max;
    logic [2:0]  cmd_mode;
    logic        cmd_keep;
    logic        cmd_abort;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic        t_rd_en;
    logic        t_wr_en;
    logic [31:0] t_address;
    logic [31:0] t_wr_data;
    logic [31:0] t_rd_data;
    logic        t_ready;
    logic        t_error;

    modport master (
        input  cmd_valid, cmd_load, cmd_pwm_thres, cmd_wd_max,
        input  cmd_mode, cmd_keep, cmd_abort,
        output cmd_ready, busy, done, result,
        output t_rd_en, t_wr_en, t_address, t_wr_data,
        input  t_rd_data, t_ready, t_error
    );

    modport slave (
        output cmd_valid, cmd_load, cmd_pwm_thres, cmd_wd_max,
        output cmd_mode, cmd_keep, cmd_abort,
        input  cmd_ready, busy, done, result,
        input  t_rd_en, t_wr_en, t_address, t_wr_data,
        output t_rd_data, t_ready, t_error
    );

endinterface

// File: rtl/timer_seq.sv
// Bus-master sequencer: programs the timer, waits for expiry by polling
// status, optionally disarms it, then pulses done with a result code.
module timer_seq
    import timer_pkg::*;
#(
    parameter logic [31:0] TIMER_BASE   = 32'h4000_0000,
    parameter int          POLL_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    timer_seq_if.master  bus
);

    localparam int CW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_TIMEOUT - 1);

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [1:0]  settle_q, settle_d;
    logic [CW-1:0] poll_q, poll_d;
    result_e     code_q, code_d;
    result_e     result_q, result_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        active;
    logic        err_win;
    logic        unused_bits;

    assign unused_bits = ^{bus.cmd_mode[0], bus.t_rd_data[31:1]};

    assign active = state_q inside {S_WR_PWM, S_WR_WDMAX, S_WR_CTRL,
                                    S_WR_LOAD, S_SETTLE, S_POLL};
    // t_error reports on the write issued one cycle earlier
    assign err_win = (state_q inside {S_WR_WDMAX, S_WR_CTRL, S_WR_LOAD})
                   || (state_q == S_SETTLE && settle_q == 2'd0);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        settle_d = settle_q;
        poll_d   = poll_q;
        code_d   = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d.load  = bus.cmd_load;
                    cmd_d.pwm   = bus.cmd_pwm_thres;
                    cmd_d.wdmax = bus.cmd_wd_max;
                    cmd_d.mode  = bus.cmd_mode[2:1];
                    cmd_d.keep  = bus.cmd_keep;
                    code_d      = RES_OK;
                    state_d     = S_WR_PWM;
                end
            end
            S_WR_PWM:   state_d = S_WR_WDMAX;
            S_WR_WDMAX: state_d = S_WR_CTRL;
            S_WR_CTRL:  state_d = S_WR_LOAD;
            S_WR_LOAD: begin
                settle_d = 2'd0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == 2'd2) begin
                    poll_d  = '0;
                    state_d = S_POLL;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            S_POLL: begin
                if (poll_q == POLL_LAST) begin
                    code_d  = RES_TIMEOUT;
                    state_d = S_DISARM;
                end else if (bus.t_ready && bus.t_rd_data[0]) begin
                    code_d  = RES_OK;
                    state_d = cmd_q.keep ? S_DONE : S_DISARM;
                end else begin
                    poll_d = poll_q + CW'(1);
                end
            end
            S_DISARM: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (active && bus.cmd_abort) begin
            code_d  = RES_ABORT;
            state_d = S_DISARM;
        end else if (err_win && bus.t_error) begin
            code_d  = RES_BUS_ERR;
            state_d = S_DISARM;
        end
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        done_d   = 1'b0;
        result_d = result_q;
        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
        unique case (state_d)
            S_WR_PWM: begin
                wr_d   = 1'b1;
                addr_d = TIMER_BASE + OFF_PWM;
                data_d = cmd_d.pwm;
            end
            S_WR_WDMAX: begin
                wr_d   = 1'b1;
                addr_d = TIMER_BASE + OFF_WDMAX;
                data_d = cmd_d.wdmax;
            end
            S_WR_CTRL: begin
                wr_d   = 1'b1;
                addr_d = TIMER_BASE + OFF_CTRL;
                data_d = {29'b0, cmd_d.mode, 1'b1};
            end
            S_WR_LOAD: begin
                wr_d   = 1'b1;
                addr_d = TIMER_BASE + OFF_LOAD;
                data_d = cmd_d.load;
            end
            S_POLL: begin
                rd_d   = 1'b1;
                addr_d = TIMER_BASE + OFF_STATUS;
            end
            S_DISARM: begin
                wr_d   = 1'b1;
                addr_d = TIMER_BASE + OFF_CTRL;
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = code_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            settle_q <= '0;
            poll_q   <= '0;
            code_q   <= RES_OK;
            result_q <= RES_OK;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            settle_q <= settle_d;
            poll_q   <= poll_d;
            code_q   <= code_d;
            result_q <= result_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.t_rd_en   = rd_q;
    assign bus.t_wr_en   = wr_q;
    assign bus.t_address = addr_q;
    assign bus.t_wr_data = data_q;

endmodule

// File: tb/tb_timer_seq.sv
// Randomized bench for timer_seq with a transaction-level timeline model
// and a per-cycle compare process.
module tb_timer_seq;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int PT   = 8;
    localparam int MAXC = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    timer_seq_if bus ();

    timer_seq #(.TIMER_BASE(BASE), .POLL_TIMEOUT(PT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        busy;
        logic        done;
        logic [1:0]  res;
    } exp_t;

    exp_t       exp_cur;
    bit         exp_on = 1'b0;
    int         cyc = -1;
    int         checks = 0;
    int         passes = 0;
    int         obs_done = -1;
    logic [1:0] obs_res = 2'b00;
    logic [1:0] prev_res = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("t_rd_en",   32'(bus.t_rd_en),   32'(exp_cur.rd));
            chk("t_wr_en",   32'(bus.t_wr_en),   32'(exp_cur.wr));
            chk("t_address", bus.t_address,      exp_cur.addr);
            chk("t_wr_data", bus.t_wr_data,      exp_cur.data);
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_cur.rdy));
            chk("busy",      32'(bus.busy),      32'(exp_cur.busy));
            chk("done",      32'(bus.done),      32'(exp_cur.done));
            chk("result",    32'(bus.result),    32'(exp_cur.res));
            if (bus.done === 1'b1) begin
                obs_done = cyc;
                obs_res  = bus.result;
            end
        end
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.data = '0;
        e.rdy = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.res = prev_res;
        return e;
    endfunction

    task automatic reset_chk(input string tag);
        chk({tag, "_rd"},    32'(bus.t_rd_en),   32'd0);
        chk({tag, "_wr"},    32'(bus.t_wr_en),   32'd0);
        chk({tag, "_addr"},  bus.t_address,      32'd0);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_res"},   32'(bus.result),    32'd0);
    endtask

    // Cycle 0 = acceptance cycle. Status reads 1 from P = max(8, 6+N).
    task automatic run_txn(input logic [31:0] n, input logic [31:0] pwm,
                           input logic [31:0] wd, input logic [2:0] mode,
                           input bit keep, input int ab_c, input int er_c,
                           input int pct, input int rst_c,
                           output int d_out, output logic [1:0] code_out);
        bit         rdy [MAXC];
        longint     p;
        int         x;
        int         d;
        bit         dis;
        logic [1:0] code;
        logic [31:0] rnd;
        exp_t       e;
        p = (longint'(n) + 6 > 8) ? longint'(n) + 6 : 8;
        for (int c = 0; c < MAXC; c++) rdy[c] = ($urandom_range(0, 99) < pct);
        x = -1;
        code = 2'b00;
        for (int c = 1; c < MAXC && x < 0; c++) begin
            if (c == ab_c) begin
                code = 2'b10; x = c;
            end else if (c >= 2 && c <= 5 && c == er_c) begin
                code = 2'b11; x = c;
            end else if (c == 7 + PT) begin
                code = 2'b01; x = c;
            end else if (c >= 8 && rdy[c] && longint'(c) >= p) begin
                code = 2'b00; x = c;
            end
        end
        dis = !(code == 2'b00 && keep);
        d = x + (dis ? 2 : 1);
        obs_done = -1;
        for (int c = 0; c <= d; c++) begin
            @(posedge clk); #1;
            cyc = c;
            bus.cmd_valid     = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.cmd_load      = (c == 0) ? n    : $urandom();
            bus.cmd_pwm_thres = (c == 0) ? pwm  : $urandom();
            bus.cmd_wd_max    = (c == 0) ? wd   : $urandom();
            bus.cmd_mode      = (c == 0) ? mode : 3'($urandom_range(0, 7));
            bus.cmd_keep      = (c == 0) ? keep : 1'($urandom_range(0, 1));
            bus.cmd_abort     = (c == ab_c);
            bus.t_error       = (c == er_c);
            bus.t_ready       = rdy[c];
            rnd = $urandom();
            rnd[0] = (longint'(c) >= p);
            bus.t_rd_data = rnd;
            if (c == rst_c) begin
                exp_on = 1'b0;
                bus.cmd_valid = 1'b0;
                #2 rst = 1'b0;
                #1 reset_chk("async_rst");
                @(posedge clk); #1;
                reset_chk("held_rst");
                rst = 1'b1;
                prev_res = 2'b00;
                d_out = -1;
                code_out = 2'b00;
                return;
            end
            e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.data = '0;
            e.rdy = (c == 0); e.busy = (c != 0); e.done = 1'b0; e.res = prev_res;
            if (c >= 1 && c <= x) begin
                if (c == 1) begin
                    e.wr = 1'b1; e.addr = BASE + 32'h0C; e.data = pwm;
                end else if (c == 2) begin
                    e.wr = 1'b1; e.addr = BASE + 32'h08; e.data = wd;
                end else if (c == 3) begin
                    e.wr = 1'b1; e.addr = BASE;
                    e.data = {29'b0, mode[2:1], 1'b1};
                end else if (c == 4) begin
                    e.wr = 1'b1; e.addr = BASE + 32'h04; e.data = n;
                end else if (c >= 8) begin
                    e.rd = 1'b1; e.addr = BASE + 32'h14;
                end
            end else if (c == x + 1 && dis) begin
                e.wr = 1'b1; e.addr = BASE;
            end
            if (c == d) begin
                e.done = 1'b1; e.res = code;
            end
            exp_cur = e;
            exp_on = 1'b1;
        end
        @(negedge clk); #1;
        prev_res = code;
        d_out = d;
        code_out = code;
    endtask

    task automatic idle_gap(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            cyc = -1;
            bus.cmd_valid = 1'b0;
            bus.cmd_abort = 1'($urandom_range(0, 1));
            bus.t_error   = 1'($urandom_range(0, 1));
            exp_cur = idle_exp();
            exp_on = 1'b1;
        end
    endtask

    task automatic pin(input string nm, input int d, input int want_d,
                       input logic [1:0] want_r);
        chk({nm, "_model_done"}, 32'(d),        32'(want_d));
        chk({nm, "_done_cyc"},   32'(obs_done), 32'(want_d));
        chk({nm, "_result"},     32'(obs_res),  32'(want_r));
    endtask

    initial begin
        int d;
        logic [1:0] r;
        logic [31:0] n;
        bus.cmd_valid = 1'b0; bus.cmd_load = '0; bus.cmd_pwm_thres = '0;
        bus.cmd_wd_max = '0; bus.cmd_mode = '0; bus.cmd_keep = 1'b0;
        bus.cmd_abort = 1'b0; bus.t_rd_data = '0; bus.t_ready = 1'b0;
        bus.t_error = 1'b0;
        #12;
        reset_chk("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        run_txn(32'd5, 32'd3, 32'h55, 3'b100, 1'b0, -1, -1, 100, -1, d, r);
        pin("normal", d, 13, 2'b00);
        run_txn(32'd0, 32'd7, 32'd9, 3'b001, 1'b1, -1, -1, 100, -1, d, r);
        pin("keep", d, 9, 2'b00);
        run_txn(32'd100, 32'd1, 32'd2, 3'b010, 1'b0, -1, -1, 100, -1, d, r);
        pin("timeout", d, 8 + PT + 1, 2'b01);
        run_txn(32'd5, 32'd2, 32'd4, 3'b110, 1'b0, 6, -1, 100, -1, d, r);
        pin("abort", d, 8, 2'b10);
        run_txn(32'd5, 32'd2, 32'd4, 3'b110, 1'b1, -1, 3, 100, -1, d, r);
        pin("buserr", d, 5, 2'b11);
        run_txn(32'd20, 32'd1, 32'd1, 3'b100, 1'b0, -1, -1, 100, 10, d, r);
        run_txn(32'd3, 32'd6, 32'd8, 3'b111, 1'b0, -1, -1, 100, -1, d, r);
        pin("after_rst", d, 11, 2'b00);

        for (int t = 0; t < 60; t++) begin
            n = ($urandom_range(0, 5) == 0) ? $urandom()
                                            : 32'($urandom_range(0, 12));
            run_txn(n, $urandom(), $urandom(), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1,
                    int'($urandom_range(50, 100)), -1, d, r);
            idle_gap(int'($urandom_range(0, 2)));
        end

        @(posedge clk); #1;
        exp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
